// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and default timeout.
package uart_pkg;

  localparam int unsigned DATA_W             = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 40000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester found starting one slot after last_grant_i.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] slot;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    sum   = '0;
    slot  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, last_grant_i} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      slot = sum[IDX_W-1:0];
      if (req_i[slot]) begin
        idx_o       = slot;
        gnt_o       = '0;
        gnt_o[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte requesters with round-robin arbitration
// and a transfer timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          sent,
  output logic                          timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_start_q, busy_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .gnt_o        (arb_gnt),
    .idx_o        (arb_idx),
    .any_o        (arb_any)
  );

  // Next-state and strobe decode; accept is gated by rst so no ready leaks during reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    req_ready   = '0;
    sent        = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rst && !tx_busy && arb_any) begin
          req_ready = arb_gnt;
          tx_data_d = req_data[{arb_idx, 3'b000} +: DATA_W];
          grant_d   = arb_idx;
          last_d    = arb_idx;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          sent    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= (state_d == START);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, timing, timeout and reset.
module tb_uart_tx_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 20;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic         tx_done;
  logic [1:0]   grant_id;
  logic         busy;
  logic         sent;
  logic         timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .sent        (sent),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stray;
    logic [3:0] exp_oh;
    logic [7:0] exp_byte;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = {8'h44, 8'h43, 8'h42, 8'h41};
    tx_busy   = 1'b0;
    tx_done   = 1'b0;

    // Reset state, including ready suppressed while requests are pending in reset
    #12;
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_tx_start",  32'(tx_start),  32'h0);
    chk("rst_tx_data",   32'(tx_data),   32'h0);
    chk("rst_grant_id",  32'(grant_id),  32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_sent",      32'(sent),      32'h0);
    chk("rst_timeout",   32'(timeout_err), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 0
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_busy_idle", 32'(busy), 32'h0);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("single_tx_start", 32'(tx_start), 32'h1);
    chk("single_tx_data",  32'(tx_data),  32'h41);
    chk("single_grant",    32'(grant_id), 32'h0);
    chk("single_busy",     32'(busy),     32'h1);
    chk("single_ready_start", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("single_start_pulse_end", 32'(tx_start), 32'h0);
    tx_done = 1'b1;
    #1;
    chk("single_sent", 32'(sent), 32'h1);
    chk("single_no_timeout", 32'(timeout_err), 32'h0);
    @(negedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_done_ignored", 32'(sent), 32'h0);
    tx_done = 1'b0;

    // Round-robin order 0,1,2,3,0 after a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_oh   = 4'b0001 << (t % 4);
      exp_byte = 8'h41 + 8'(t % 4);
      if (t != 0) @(negedge clk);
      tx_done = 1'b0;
      #1;
      chk("rr_ready", 32'(req_ready), 32'(exp_oh));
      @(negedge clk);
      #1;
      chk("rr_start", 32'(tx_start), 32'h1);
      chk("rr_grant", 32'(grant_id), 32'(t % 4));
      chk("rr_data",  32'(tx_data),  32'(exp_byte));
      @(negedge clk);
      tx_done = 1'b1;
      #1;
      chk("rr_sent", 32'(sent), 32'h1);
    end
    @(negedge clk);
    tx_done   = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("rr_end_ready", 32'(req_ready), 32'h0);
    chk("rr_end_busy",  32'(busy),      32'h0);

    // Timeout: requester 1, tx_done withheld
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("tmo_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("tmo_tx_start", 32'(tx_start), 32'h1);
    stray = 0;
    for (int k = 1; k < int'(TMO); k++) begin
      @(negedge clk);
      #1;
      if (timeout_err !== 1'b0 || sent !== 1'b0) stray++;
    end
    chk("tmo_no_early_pulse", 32'(stray), 32'h0);
    @(negedge clk);
    #1;
    chk("tmo_err_pulse", 32'(timeout_err), 32'h1);
    chk("tmo_no_sent",   32'(sent),        32'h0);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("tmo_err_single", 32'(timeout_err), 32'h0);
    chk("tmo_idle_busy",  32'(busy),        32'h0);
    chk("tmo_next_ready", 32'(req_ready),   32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("tmo_next_data", 32'(tx_data), 32'h41);
    @(negedge clk);
    tx_done = 1'b1;
    #1;
    chk("tmo_next_sent", 32'(sent), 32'h1);

    // tx_done coincident with expiry counts as success
    @(negedge clk);
    tx_done   = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("edge_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    for (int k = 1; k < int'(TMO); k++) @(negedge clk);
    @(negedge clk);
    tx_done = 1'b1;
    #1;
    chk("edge_sent",       32'(sent),        32'h1);
    chk("edge_no_timeout", 32'(timeout_err), 32'h0);
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("edge_idle", 32'(busy), 32'h0);

    // Asynchronous reset during WAIT_DONE
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    chk("arst_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("arst_pre_grant", 32'(grant_id), 32'h3);
    #2;
    rst       = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("arst_busy",     32'(busy),        32'h0);
    chk("arst_tx_data",  32'(tx_data),     32'h0);
    chk("arst_grant",    32'(grant_id),    32'h0);
    chk("arst_tx_start", 32'(tx_start),    32'h0);
    chk("arst_ready0",   32'(req_ready),   32'h0);
    chk("arst_sent",     32'(sent),        32'h0);
    chk("arst_timeout",  32'(timeout_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_after_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("arst_after_grant", 32'(grant_id), 32'h2);
    chk("arst_after_data",  32'(tx_data),  32'h43);
    @(negedge clk);
    tx_done = 1'b1;
    #1;
    chk("arst_after_sent", 32'(sent), 32'h1);

    // tx_busy blocks acceptance until it falls
    @(negedge clk);
    tx_done   = 1'b0;
    tx_busy   = 1'b1;
    req_valid = 4'b0011;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (req_ready !== 4'b0000) stray++;
      @(negedge clk);
    end
    chk("txbusy_no_ready", 32'(stray), 32'h0);
    tx_busy = 1'b0;
    #1;
    chk("txbusy_release_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("txbusy_grant", 32'(grant_id), 32'h0);
    chk("txbusy_data",  32'(tx_data),  32'h41);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
